ps2_key_hub: RTL and testbench
==============================

PS2_KEY_HUB -- requirements
Module: ps2_key_hub

Interface
REQ-001 Parameter N_DIGITS, default 8, even count 2..8 of seven-segment digits driven.
REQ-002 Parameter FIFO_DEPTH, default 16, power of two 4..64, key-event queue depth.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_pressed  input  1  one-cycle strobe: key_data holds a new PS/2 byte.
REQ-006 key_data  input  8  raw scan-code byte from the PS/2 interface.
REQ-007 rd_en  input  1  consumer pop request for the event queue.
REQ-008 rd_data  output  10  head event: bit9 break, bit8 extended, bits7:0 code.
REQ-009 empty  output  1  event queue empty.
REQ-010 full  output  1  event queue holds FIFO_DEPTH entries.
REQ-011 overflow  output  1  sticky flag: an event was dropped.
REQ-012 dir_held  output  4  held extended arrows {up E0-75, down E0-72, left E0-6B, right E0-74}, bits 3..0.
REQ-013 seg  output  7*N_DIGITS  active-low segments, digit k at bits 7k+6:7k, hex encoding unchanged from the current seven-segment driver.

Function
REQ-014 Decoder FSM states IDLE, EXT, BRK, EXT_BRK; advances only on key_pressed.
REQ-015 IDLE: E0 -> EXT; F0 -> BRK; any other byte emits make event {0,0,byte}, stays IDLE.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> EXT; other byte emits {0,1,byte} -> IDLE.
REQ-017 BRK: byte emits {1,0,byte} -> IDLE; EXT_BRK: byte emits {1,1,byte} -> IDLE.
REQ-018 Event emitted on key_pressed cycle t is visible at rd_data with empty=0 from cycle t+1 (show-ahead queue).
REQ-019 rd_en with empty=0 pops head at the edge; rd_en with empty=1 is ignored, no state change.
REQ-020 Push when full and rd_en=0: event dropped, overflow set; queue contents unchanged.
REQ-021 Push when full and rd_en=1 same cycle: pop and push both performed, no overflow.
REQ-022 Push and pop same cycle when empty: push only; entry visible next cycle.
REQ-023 Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-024 overflow clears only on reset.
REQ-025 dir_held bit set on matching extended make, cleared on matching extended break, both at t+1; repeat makes keep it set.
REQ-026 History register of N_DIGITS/2 bytes shifts on each make event; newest code on digits 1:0, older codes on higher digit pairs; break events not recorded.
REQ-027 seg is a combinational decode of the history register; no extra latency beyond REQ-026.

Reset
REQ-028 On reset: FSM IDLE, queue empty (empty=1, full=0), overflow=0, dir_held=0, history=0 (all digits show 0), rd_data=0.
REQ-029 Reset mid-sequence (after E0 or F0) discards the prefix; the next byte decodes from IDLE.

Configuration
REQ-030 With PS2_REMAP_EN defined, make and break codes of non-extended events are remapped before queue and history: 75->12, 33->48, 23->44, 34->47, others unchanged.
REQ-031 Without PS2_REMAP_EN, codes pass unmodified; extended events are never remapped in either build.

Structure
REQ-032 Shared package holds event field positions, the decoder state enumeration, prefix constants E0/F0, arrow codes and the remap table.
REQ-033 Queue is one sub-module ps2_event_fifo, parametrised by depth and width 10.

Verification
REQ-034 Bytes 1C -> event 01C at t+1; history digits 1:0 show "1C"; empty=0.
REQ-035 E0,75 then E0,F0,75 -> dir_held=1000 after first pair, 0000 after second; events 175 then 375.
REQ-036 FIFO_DEPTH+1 make codes, no reads -> full=1, overflow=1, first FIFO_DEPTH codes read back in order.
REQ-037 Full queue, push with rd_en=1 -> overflow stays 0, count unchanged, new event at tail.
REQ-038 F0 then reset then 2B -> make event 02B, not a break.
REQ-039 PS2_REMAP_EN build: byte 75 -> event 012; E0,75 -> event 175.

Source files
------------

// File: rtl/ps2_key_hub_pkg.sv
// Shared types and constants for the PS/2 key hub: event layout, decoder states,
// prefix bytes, arrow codes, scan-code remap table and seven-segment hex decode.
package ps2_key_hub_pkg;

    localparam int unsigned EvWidth = 10;

    // Bit 9 break, bit 8 extended, bits 7:0 scan code.
    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } dec_state_e;

    localparam logic [7:0] PrefixExt = 8'hE0;
    localparam logic [7:0] PrefixBrk = 8'hF0;

    localparam logic [7:0] CodeUp    = 8'h75;
    localparam logic [7:0] CodeDown  = 8'h72;
    localparam logic [7:0] CodeLeft  = 8'h6B;
    localparam logic [7:0] CodeRight = 8'h74;

    // Applies to non-extended codes only.
    function automatic logic [7:0] remap_code(input logic [7:0] code);
        logic [7:0] res;
        res = code;
        case (code)
            8'h75:   res = 8'h12;
            8'h33:   res = 8'h48;
            8'h23:   res = 8'h44;
            8'h34:   res = 8'h47;
            default: res = code;
        endcase
        return res;
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event queue with sticky overflow; a push into a full queue is kept
// only when a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DepthCount = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DepthCount);
    assign overflow = overflow_q;
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
            if (push && !do_push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ps2_key_hub.sv
// PS/2 scan-code decoder feeding an event queue, arrow-key state and a hex history display.
// Define PS2_REMAP_EN to remap selected non-extended scan codes.
module ps2_key_hub
    import ps2_key_hub_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  key_pressed,
    input  logic [7:0]            key_data,
    input  logic                  rd_en,
    output logic [EvWidth-1:0]    rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic [3:0]            dir_held,
    output logic [7*N_DIGITS-1:0] seg
);

    localparam int unsigned HW = 4 * N_DIGITS;

    dec_state_e    state_q, state_d;
    logic          emit;
    ps2_event_t    ev;
    logic [3:0]    dir_q, dir_d;
    logic [HW-1:0] hist_q, hist_d;

    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev.brk  = 1'b0;
        ev.ext  = 1'b0;
        if (key_pressed) begin
            unique case (state_q)
                StIdle: begin
                    if (key_data == PrefixExt)      state_d = StExt;
                    else if (key_data == PrefixBrk) state_d = StBrk;
                    else                            emit    = 1'b1;
                end
                StExt: begin
                    if (key_data == PrefixBrk) begin
                        state_d = StExtBrk;
                    end else if (key_data != PrefixExt) begin
                        emit    = 1'b1;
                        ev.ext  = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBrk: begin
                    emit    = 1'b1;
                    ev.brk  = 1'b1;
                    state_d = StIdle;
                end
                StExtBrk: begin
                    emit    = 1'b1;
                    ev.brk  = 1'b1;
                    ev.ext  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
`ifdef PS2_REMAP_EN
        ev.code = ev.ext ? key_data : remap_code(key_data);
`else
        ev.code = key_data;
`endif
    end

    always_comb begin
        dir_d  = dir_q;
        hist_d = hist_q;
        if (emit) begin
            if (ev.ext) begin
                case (ev.code)
                    CodeUp:    dir_d[3] = !ev.brk;
                    CodeDown:  dir_d[2] = !ev.brk;
                    CodeLeft:  dir_d[1] = !ev.brk;
                    CodeRight: dir_d[0] = !ev.brk;
                    default:   dir_d    = dir_q;
                endcase
            end
            if (!ev.brk) hist_d = (hist_q << 8) | HW'(ev.code);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            dir_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            hist_q  <= hist_d;
        end
    end

    assign dir_held = dir_q;

    // Digit k shows nibble k of the history; newest byte sits on digits 1:0.
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_seg
        assign seg[7*k +: 7] = hex_to_seg(hist_q[4*k +: 4]);
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EvWidth)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (emit),
        .push_data (ev),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_ps2_key_hub.sv
// Self-checking bench for ps2_key_hub: queue-based reference model compared every
// cycle, plus literal expectations for the key scenarios.
module tb_ps2_key_hub;

    localparam int ND = 8;
    localparam int FD = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            key_pressed = 1'b0;
    logic [7:0]      key_data = 8'h00;
    logic            rd_en = 1'b0;
    logic [9:0]      rd_data;
    logic            empty, full, overflow;
    logic [3:0]      dir_held;
    logic [7*ND-1:0] seg;

    ps2_key_hub #(
        .N_DIGITS   (ND),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_pressed (key_pressed),
        .key_data    (key_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .dir_held    (dir_held),
        .seg         (seg)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [7:0] ARROW [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

    logic [9:0] mq[$];
    bit         m_ext, m_brk, m_ovf, started;
    logic [3:0] m_dir;
    logic [7:0] m_hist [ND/2];
    logic [7:0] m_code;

    function automatic logic [7:0] model_remap(input logic [7:0] c);
        if (c == 8'h75) return 8'h12;
        if (c == 8'h33) return 8'h48;
        if (c == 8'h23) return 8'h44;
        if (c == 8'h34) return 8'h47;
        return c;
    endfunction

    function automatic logic [7*ND-1:0] exp_seg();
        logic [7*ND-1:0] s;
        logic [3:0]      nib;
        s = '0;
        for (int k = 0; k < ND/2; k++) begin
            for (int h = 0; h < 2; h++) begin
                nib = (h == 1) ? m_hist[k][7:4] : m_hist[k][3:0];
                s[7*(2*k+h) +: 7] = HEX[nib];
            end
        end
        return s;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_ovf = 0; m_dir = '0;
            for (int k = 0; k < ND/2; k++) m_hist[k] = 8'h00;
            started = 1;
        end else begin
            if (rd_en && mq.size() > 0) void'(mq.pop_front());
            if (key_pressed) begin
                if (!m_brk && key_data == 8'hE0) m_ext = 1;
                else if (!m_brk && key_data == 8'hF0) m_brk = 1;
                else begin
                    m_code = key_data;
`ifdef PS2_REMAP_EN
                    if (!m_ext) m_code = model_remap(key_data);
`endif
                    if (mq.size() < FD) mq.push_back({m_brk, m_ext, m_code});
                    else m_ovf = 1;
                    if (m_ext)
                        for (int i = 0; i < 4; i++)
                            if (m_code == ARROW[i]) m_dir[3-i] = !m_brk;
                    if (!m_brk) begin
                        for (int k = ND/2 - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                        m_hist[0] = m_code;
                    end
                    m_ext = 0; m_brk = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("rd_data",  rd_data,  (mq.size() > 0) ? mq[0] : 10'h000);
            chk("empty",    empty,    mq.size() == 0);
            chk("full",     full,     mq.size() == FD);
            chk("overflow", overflow, m_ovf);
            chk("dir_held", dir_held, m_dir);
            chk("seg",      seg,      exp_seg());
        end
    end

    task automatic step(input bit kp, input logic [7:0] d, input bit rd);
        key_pressed = kp; key_data = d; rd_en = rd;
        @(posedge clock);
        #1;
        key_pressed = 1'b0; rd_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2*FD && !empty; i++) pop1();
        chk("drained", empty, 1'b1);
    endtask

    initial begin
        do_reset();
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_dir", dir_held, 4'h0);
        chk("rst_rd", rd_data, 10'h000);
        chk("rst_seg", seg, {ND{7'h40}});

        send(8'h1C);
        chk("make_1c", rd_data, 10'h01C);
        chk("make_1c_empty", empty, 1'b0);
        chk("make_1c_seg", seg[13:0], {7'h79, 7'h46});
        pop1();

        send(8'hE0); send(8'h75);
        chk("up_make_dir", dir_held, 4'b1000);
        chk("up_make_ev", rd_data, 10'h175);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_brk_dir", dir_held, 4'b0000);
        pop1();
        chk("up_brk_ev", rd_data, 10'h375);
        pop1();

        send(8'hE0); send(8'h72); send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h74); send(8'hE0); send(8'h74);
        chk("arrows_dir", dir_held, 4'b0111);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("left_brk_dir", dir_held, 4'b0101);
        drain();

        send(8'h75);
`ifdef PS2_REMAP_EN
        chk("remap_75", rd_data, 10'h012);
`else
        chk("plain_75", rd_data, 10'h075);
`endif
        pop1();
        send(8'hF0); send(8'h33);
`ifdef PS2_REMAP_EN
        chk("remap_brk_33", rd_data, 10'h248);
`else
        chk("plain_brk_33", rd_data, 10'h233);
`endif
        pop1();

        // Overflow: one push beyond capacity with no reads
        do_reset();
        for (int i = 0; i <= FD; i++) send(8'h10 + 8'(i));
        chk("fill_full", full, 1'b1);
        chk("fill_ovf", overflow, 1'b1);
        for (int i = 0; i < FD; i++) begin
            chk("fill_order", rd_data, {2'b00, 8'h10 + 8'(i)});
            pop1();
        end
        chk("fill_empty", empty, 1'b1);
        chk("ovf_sticky", overflow, 1'b1);

        // Simultaneous push and pop on a full queue
        do_reset();
        for (int i = 0; i < FD; i++) send(8'h40 + 8'(i));
        chk("pp_full_before", full, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        chk("pp_ovf", overflow, 1'b0);
        chk("pp_full_after", full, 1'b1);
        chk("pp_head", rd_data, 10'h041);
        for (int i = 0; i < FD-1; i++) pop1();
        chk("pp_tail", rd_data, 10'h05A);
        pop1();

        // Push and pop together on an empty queue, then pop on empty
        step(1'b1, 8'h29, 1'b1);
        chk("ep_empty", empty, 1'b0);
        chk("ep_head", rd_data, 10'h029);
        pop1();
        pop1();
        chk("pop_on_empty", empty, 1'b1);

        // Reset discards a pending break prefix
        send(8'hF0);
        do_reset();
        send(8'h2B);
        chk("prefix_discard", rd_data, 10'h02B);
        pop1();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
